// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: MMIO-mapped 8N1 serial transmitter.
// CPU stores to TXDATA queue bytes in a circular FIFO; a START/DATA/STOP
// state machine shifts them out LSB first at DIVISOR+1 clocks per bit.
// Register reads are combinational and have no side effects.
module mmio_uart_tx #(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter logic [15:0] DIV_RESET  = 16'd867
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [29:0] i_mmio_addr,
    input  logic [31:0] i_mmio_data,
    input  logic [3:0]  i_mmio_mask,
    input  logic        i_mmio_wren,
    output logic [31:0] o_mmio_data,
    output logic        o_tx
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_e;

    state_e             state_q;
    logic [2:0]         bit_cnt_q;
    logic [15:0]        baud_cnt_q;
    logic [15:0]        div_q;
    logic [7:0]         shift_q;
    logic               tx_q;

    logic [7:0]         mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q;
    logic [PTR_W-1:0]   rd_ptr_q;
    logic [CNT_W-1:0]   count_q;
    logic [CNT_W-1:0]   count_d;
    logic               ovf_q;
    logic               ovf_d;
    logic [15:0]        divisor_q;
    logic [15:0]        divisor_d;
    logic [31:0]        rdata_s;

    logic               wr_txdata_s;
    logic               wr_status_s;
    logic               wr_div_s;
    logic               full_s;
    logic               empty_s;
    logic               push_s;
    logic               pop_s;
    logic               baud_done_s;
    logic               busy_s;
    logic               unused_s;

    assign wr_txdata_s = i_mmio_wren && (i_mmio_addr[1:0] == 2'd0) && i_mmio_mask[0];
    assign wr_status_s = i_mmio_wren && (i_mmio_addr[1:0] == 2'd1) && i_mmio_mask[0]
                         && i_mmio_data[3];
    assign wr_div_s    = i_mmio_wren && (i_mmio_addr[1:0] == 2'd2);

    // full is taken from the registered count, i.e. before this edge's pop,
    // so a push into a full FIFO is dropped even if a pop frees a slot now.
    assign full_s      = (count_q == CNT_W'(FIFO_DEPTH));
    assign empty_s     = (count_q == {CNT_W{1'b0}});
    assign push_s      = wr_txdata_s && !full_s;
    assign baud_done_s = (baud_cnt_q == div_q);
    assign pop_s       = !empty_s && ((state_q == ST_IDLE) ||
                                      ((state_q == ST_STOP) && baud_done_s));
    assign busy_s      = (state_q != ST_IDLE);
    assign unused_s    = ^{i_mmio_addr[29:2], i_mmio_data[31:16]};

    // Next-state for FIFO occupancy, overflow flag and DIVISOR register.
    always_comb begin
        count_d   = count_q;
        ovf_d     = ovf_q;
        divisor_d = divisor_q;
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_W'(1'b1);
            2'b01:   count_d = count_q - CNT_W'(1'b1);
            default: count_d = count_q;
        endcase
        // A dropped push outranks a simultaneous clear so the loss is never hidden.
        if (wr_txdata_s && full_s) begin
            ovf_d = 1'b1;
        end else if (wr_status_s) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
        if (wr_div_s && i_mmio_mask[0]) begin
            divisor_d[7:0] = i_mmio_data[7:0];
        end else begin
            divisor_d[7:0] = divisor_q[7:0];
        end
        if (wr_div_s && i_mmio_mask[1]) begin
            divisor_d[15:8] = i_mmio_data[15:8];
        end else begin
            divisor_d[15:8] = divisor_q[15:8];
        end
    end

    // FIFO pointers, count, overflow flag and DIVISOR register.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q  <= {PTR_W{1'b0}};
            rd_ptr_q  <= {PTR_W{1'b0}};
            count_q   <= {CNT_W{1'b0}};
            ovf_q     <= 1'b0;
            divisor_q <= DIV_RESET;
        end else begin
            if (push_s) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1'b1);
            end
            if (pop_s) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1'b1);
            end
            count_q   <= count_d;
            ovf_q     <= ovf_d;
            divisor_q <= divisor_d;
        end
    end

    // FIFO storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= i_mmio_data[7:0];
        end
    end

    // Transmit FSM: every state lasts div_q+1 clocks; div_q is latched at each
    // pop so DIVISOR writes during a frame only affect the following frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            bit_cnt_q  <= 3'd0;
            baud_cnt_q <= 16'd0;
            div_q      <= 16'd0;
            shift_q    <= 8'd0;
            tx_q       <= 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    tx_q <= 1'b1;
                    if (pop_s) begin
                        shift_q    <= mem_q[rd_ptr_q];
                        div_q      <= divisor_q;
                        baud_cnt_q <= 16'd0;
                        state_q    <= ST_START;
                        tx_q       <= 1'b0;
                    end
                end
                ST_START: begin
                    if (baud_done_s) begin
                        baud_cnt_q <= 16'd0;
                        bit_cnt_q  <= 3'd0;
                        state_q    <= ST_DATA;
                        tx_q       <= shift_q[0];
                    end else begin
                        baud_cnt_q <= baud_cnt_q + 16'd1;
                    end
                end
                ST_DATA: begin
                    if (baud_done_s) begin
                        baud_cnt_q <= 16'd0;
                        if (bit_cnt_q == 3'd7) begin
                            state_q <= ST_STOP;
                            tx_q    <= 1'b1;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                            shift_q   <= {1'b0, shift_q[7:1]};
                            tx_q      <= shift_q[1];
                        end
                    end else begin
                        baud_cnt_q <= baud_cnt_q + 16'd1;
                    end
                end
                ST_STOP: begin
                    if (baud_done_s) begin
                        baud_cnt_q <= 16'd0;
                        if (pop_s) begin
                            shift_q <= mem_q[rd_ptr_q];
                            div_q   <= divisor_q;
                            state_q <= ST_START;
                            tx_q    <= 1'b0;
                        end else begin
                            state_q <= ST_IDLE;
                            tx_q    <= 1'b1;
                        end
                    end else begin
                        baud_cnt_q <= baud_cnt_q + 16'd1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    tx_q    <= 1'b1;
                end
            endcase
        end
    end

    // Register read mux; combinational from the address, no side effects.
    always_comb begin
        rdata_s = 32'h0000_0000;
        case (i_mmio_addr[1:0])
            2'd1:    rdata_s = {16'h0000, 8'(count_q), 4'h0, ovf_q, busy_s, full_s, empty_s};
            2'd2:    rdata_s = {16'h0000, divisor_q};
            default: rdata_s = 32'h0000_0000;
        endcase
    end

    assign o_mmio_data = rdata_s;
    assign o_tx        = tx_q;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Self-checking bench for mmio_uart_tx. Every accepted byte is pushed to a
// scoreboard together with the bit period it must be sent with; an independent
// monitor decodes the serial line and compares every clock of every frame.
module tb_mmio_uart_tx;

    localparam int          DEPTH   = 8;
    localparam logic [15:0] DIV_RST = 16'd867;

    logic        clk = 1'b0;
    logic        rst;
    logic [29:0] addr;
    logic [31:0] wdata;
    logic [3:0]  mask;
    logic        wren;
    logic [31:0] rdata;
    logic        tx;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [15:0] cur_div;        // divisor the next accepted byte will be sent with
    logic [23:0] sb[$];          // {bit period - 1, byte}, bytes not yet started

    mmio_uart_tx #(.FIFO_DEPTH(DEPTH), .DIV_RESET(DIV_RST)) dut (
        .clk(clk), .rst(rst), .i_mmio_addr(addr), .i_mmio_data(wdata),
        .i_mmio_mask(mask), .i_mmio_wren(wren), .o_mmio_data(rdata), .o_tx(tx)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_cycle(input int c);
        while (cyc < c) step(1);
    endtask

    task automatic do_write(input logic [1:0] off, input logic [31:0] d, input logic [3:0] m);
        addr  = {28'd0, off};
        wdata = d;
        mask  = m;
        wren  = 1'b1;
        @(posedge clk);
        #1;
        wren = 1'b0;
        mask = 4'h0;
    endtask

    task automatic rd(input logic [1:0] off, output logic [31:0] d);
        addr = {28'd0, off};
        #1;
        d = rdata;
    endtask

    task automatic push_byte(input logic [7:0] b, input bit accept);
        logic [31:0] d;
        logic [3:0]  m;
        d      = $urandom;
        d[7:0] = b;
        m      = 4'($urandom);
        m[0]   = 1'b1;
        if (accept) sb.push_back({cur_div, b});
        do_write(2'd0, d, m);
    endtask

    task automatic set_div(input logic [15:0] v);
        cur_div = v;
        do_write(2'd2, {16'hA5A5, v}, 4'b0011);
    endtask

    task automatic wait_idle();
        logic [31:0] s;
        int          n;
        n = 0;
        rd(2'd1, s);
        while ((s[2] || sb.size() != 0) && n < 5000) begin
            step(1);
            rd(2'd1, s);
            n++;
        end
        chk("drain_timeout", 32'(n >= 5000), 32'd0);
        step(2);
    endtask

    // Monitor: decode frames from the line, each bit held div+1 clocks.
    initial begin
        logic [23:0] ent;
        int          d;
        bit          ab;
        logic        exp_b;
        forever begin
            @(negedge clk);
            if (!rst && tx === 1'b0) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL tx_idle: got tx=0 expected 1 with nothing queued (cycle %0d)", cyc);
                end else begin
                    ent = sb.pop_front();
                    d   = int'(ent[23:8]);
                    ab  = 1'b0;
                    for (int s = 0; s < 10 && !ab; s++) begin
                        for (int c = 0; c <= d && !ab; c++) begin
                            if (!(s == 0 && c == 0)) @(negedge clk);
                            if (rst) begin
                                ab = 1'b1;
                            end else begin
                                exp_b = (s == 0) ? 1'b0 : (s == 9) ? 1'b1 : ent[s-1];
                                chk("tx_bit", 32'(tx), 32'(exp_b));
                            end
                        end
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] r, r2;
        int          e0, n;
        rst = 1'b1; addr = 30'd0; wdata = 32'd0; mask = 4'h0; wren = 1'b0;
        cur_div = DIV_RST;
        step(3);
        // Reset state
        rd(2'd1, r); chk("rst_status", r, 32'h0000_0001);
        chk("rst_tx", 32'(tx), 32'd1);
        rd(2'd2, r); chk("rst_divisor", r, {16'h0000, DIV_RST});
        rst = 1'b0;
        step(1);
        rd(2'd1, r); chk("idle_status", r, 32'h0000_0001);

        // 1: single frame, latency and frame length
        set_div(16'd3);
        rd(2'd2, r); chk("div_write", r, 32'h0000_0003);
        push_byte(8'hA5, 1'b1);
        rd(2'd1, r); chk("t1_status_queued", r, 32'h0000_0100);
        chk("t1_tx_before_pop", 32'(tx), 32'd1);
        step(1);
        chk("t1_tx_start", 32'(tx), 32'd0);
        rd(2'd1, r); chk("t1_status_popped", r, 32'h0000_0005);
        n = 1;
        while (r[2] && n < 1000) begin
            step(1);
            rd(2'd1, r);
            if (r[2]) n++;
        end
        chk("t1_busy_len", 32'(n), 32'(10 * (3 + 1)));
        wait_idle();

        // 2: three bytes queued behind an active frame, contiguous output
        push_byte(8'h11, 1'b1);
        e0 = cyc;
        push_byte(8'h3C, 1'b1);
        push_byte(8'hC3, 1'b1);
        push_byte(8'h7E, 1'b1);
        rd(2'd1, r); chk("t2_count3", 32'(r[15:8]), 32'd3);
        wait_cycle(e0 + 40);
        rd(2'd1, r); chk("t2_count_before_pop", 32'(r[15:8]), 32'd3);
        wait_cycle(e0 + 41);
        rd(2'd1, r); chk("t2_count_after_pop", 32'(r[15:8]), 32'd2);
        wait_cycle(e0 + 120);
        rd(2'd1, r); chk("t2_before_third_pop", r, 32'h0000_0104);
        wait_cycle(e0 + 121);
        rd(2'd1, r); chk("t2_empty_after_third_pop", r, 32'h0000_0005);
        wait_cycle(e0 + 160);
        rd(2'd1, r); chk("t2_busy_last_clock", 32'(r[2]), 32'd1);
        wait_cycle(e0 + 161);
        rd(2'd1, r); chk("t2_idle_after_4_frames", r, 32'h0000_0001);
        wait_idle();

        // 3: overflow while a frame is active, W1C of ovf
        push_byte(8'h01, 1'b1);
        for (int k = 0; k <= DEPTH; k++) push_byte(8'(8'h40 + k), k < DEPTH);
        rd(2'd1, r); chk("t3_full_ovf", r, 32'h0000_080E);
        do_write(2'd1, 32'h0000_0000, 4'b0001);
        rd(2'd1, r); chk("t3_ovf_kept_data0", 32'(r[3]), 32'd1);
        do_write(2'd1, 32'h0000_0008, 4'b0000);
        rd(2'd1, r); chk("t3_ovf_kept_mask0", 32'(r[3]), 32'd1);
        do_write(2'd1, 32'h0000_0008, 4'b0001);
        rd(2'd1, r); chk("t3_ovf_cleared", 32'(r[3]), 32'd0);
        wait_idle();

        // 4: byte-masked DIVISOR writes, mid-frame divisor change
        do_write(2'd2, 32'h0000_1200, 4'b0010);
        rd(2'd2, r); chk("t4_div_hi_only", r, 32'h0000_1203);
        do_write(2'd2, 32'hFFFF_0003, 4'b1111);
        rd(2'd2, r); chk("t4_div_full", r, 32'h0000_0003);
        push_byte(8'h96, 1'b1);
        step(10);
        set_div(16'd1);
        push_byte(8'h4B, 1'b1);
        wait_idle();

        // 5: reset in the middle of a data bit
        set_div(16'd3);
        push_byte(8'h5A, 1'b1);
        push_byte(8'h77, 1'b1);
        step(12);
        rst = 1'b1;
        sb.delete();
        step(1);
        chk("t5_tx_after_rst", 32'(tx), 32'd1);
        rst = 1'b0;
        rd(2'd1, r); chk("t5_status_after_rst", r, 32'h0000_0001);
        rd(2'd2, r); chk("t5_div_after_rst", r, {16'h0000, DIV_RST});
        step(100);
        chk("t5_tx_quiet", 32'(tx), 32'd1);
        rd(2'd1, r); chk("t5_still_idle", r, 32'h0000_0001);

        // 6: reserved/TXDATA reads, side-effect-free STATUS reads
        set_div(16'd3);
        do_write(2'd3, 32'hFFFF_FFFF, 4'hF);
        rd(2'd3, r); chk("t6_reserved_read", r, 32'h0000_0000);
        rd(2'd0, r); chk("t6_txdata_read", r, 32'h0000_0000);
        rd(2'd2, r); chk("t6_div_unchanged", r, 32'h0000_0003);
        push_byte(8'hE1, 1'b1);
        rd(2'd1, r); rd(2'd1, r2);
        chk("t6_status_repeat", r2, r);
        chk("t6_status_value", r, 32'h0000_0100);
        wait_idle();

        // Random traffic, including DIVISOR=0 and non-pushing TXDATA writes
        for (int blk = 0; blk < 3; blk++) begin
            set_div(16'($urandom_range(0, 2)));
            for (int i = 0; i < 8; i++) begin
                step($urandom_range(0, 6));
                if ($urandom_range(0, 4) == 0) do_write(2'd0, $urandom, 4'b1110);
                if (sb.size() < DEPTH - 1) push_byte(8'($urandom), 1'b1);
            end
            wait_idle();
        end
        rd(2'd1, r); chk("final_status", r, 32'h0000_0001);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
